// File: rtl/seq_gen.sv
// seq_gen: bit-serial pattern transmitter.
// Sends a latched PAT_W-bit pattern MSB-first, repeat_cnt times, with GAP idle
// cycles between frames. All outputs are registered.
// Optional feature: define SEQ_GEN_PARITY_EN to append an even-parity bit
// (^pattern) to every frame.
module seq_gen #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

`ifdef SEQ_GEN_PARITY_EN
    localparam int FRAME_W = PAT_W + 1;
`else
    localparam int FRAME_W = PAT_W;
`endif
    localparam int BW = $clog2(FRAME_W);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_W - 1);
`ifdef SEQ_GEN_PARITY_EN
    localparam logic [BW-1:0] PAT_LAST = BW'(PAT_W - 1);
`endif
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;        // latched pattern, reloaded every frame
    logic [PAT_W-1:0] sh_q, sh_d;          // bits of the current frame still to send
    logic [CNT_W-1:0] frames_q, frames_d;  // frames remaining, including the current one
    logic [BW-1:0]    bit_q, bit_d;        // index of the frame bit currently on dout
    logic [GW-1:0]    gap_q, gap_d;        // idle cycles already spent in GAP
`ifdef SEQ_GEN_PARITY_EN
    logic             par_q, par_d;        // even parity of the latched pattern
`endif
    logic             dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state and registered-output logic; outputs default to the idle values.
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        sh_d     = sh_q;
        frames_d = frames_q;
        bit_d    = bit_q;
        gap_d    = gap_q;
`ifdef SEQ_GEN_PARITY_EN
        par_d    = par_q;
`endif
        dout_d   = 1'b0;
        valid_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    pat_d    = pattern;
                    frames_d = repeat_cnt;
                    bit_d    = '0;
                    gap_d    = '0;
`ifdef SEQ_GEN_PARITY_EN
                    par_d    = ^pattern;
`endif
                    if (repeat_cnt == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SEND;
                        dout_d  = pattern[PAT_W-1];
                        sh_d    = pattern << 1;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_SEND: begin
                if (bit_q != BIT_LAST) begin
                    // Still inside the frame: present the next bit.
                    bit_d   = bit_q + 1'b1;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
`ifdef SEQ_GEN_PARITY_EN
                    if (bit_q == PAT_LAST) begin
                        dout_d = par_q;
                    end else begin
                        dout_d = sh_q[PAT_W-1];
                        sh_d   = sh_q << 1;
                    end
`else
                    dout_d = sh_q[PAT_W-1];
                    sh_d   = sh_q << 1;
`endif
                end else begin
                    // Last bit of the frame is on the line now.
                    bit_d = '0;
                    if (frames_q == ONE) begin
                        frames_d = '0;
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                    end else begin
                        frames_d = frames_q - ONE;
                        busy_d   = 1'b1;
                        if (GAP == 0) begin
                            state_d = S_SEND;
                            dout_d  = pat_q[PAT_W-1];
                            sh_d    = pat_q << 1;
                            valid_d = 1'b1;
                        end else begin
                            state_d = S_GAP;
                            gap_d   = '0;
                        end
                    end
                end
            end

            S_GAP: begin
                busy_d = 1'b1;
                if (gap_q == GAP_LAST) begin
                    state_d = S_SEND;
                    gap_d   = '0;
                    dout_d  = pat_q[PAT_W-1];
                    sh_d    = pat_q << 1;
                    valid_d = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            pat_q    <= '0;
            sh_q     <= '0;
            frames_q <= '0;
            bit_q    <= '0;
            gap_q    <= '0;
`ifdef SEQ_GEN_PARITY_EN
            par_q    <= 1'b0;
`endif
            dout_q   <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            sh_q     <= sh_d;
            frames_q <= frames_d;
            bit_q    <= bit_d;
            gap_q    <= gap_d;
`ifdef SEQ_GEN_PARITY_EN
            par_q    <= par_d;
`endif
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// Testbench for seq_gen. A reference model expands each transfer request into
// the expected per-cycle output stream {dout, dout_valid, busy, done}, which is
// replayed cycle by cycle against the DUT. Honours SEQ_GEN_PARITY_EN.
module tb_seq_gen;

    localparam int PAT_W = 4;
    localparam int CNT_W = 4;
    localparam int GAP   = 1;
`ifdef SEQ_GEN_PARITY_EN
    localparam int FW = PAT_W + 1;
`else
    localparam int FW = PAT_W;
`endif

    logic             clk;
    logic             reset;
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_cnt;
    logic             dout;
    logic             dout_valid;
    logic             busy;
    logic             done;

    int    pass_cnt  = 0;
    int    total_cnt = 0;
    string cur_test  = "init";

    // One expected cycle plus how the inputs are driven for the following edge.
    typedef struct packed {
        logic [3:0]       o;       // {dout, dout_valid, busy, done}
        logic             fixed;   // 1: drive d_* exactly; 0: drive random noise
        logic             d_start;
        logic [PAT_W-1:0] d_pat;
        logic [CNT_W-1:0] d_cnt;
    } exp_t;

    exp_t exp_q[$];

    seq_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP(GAP)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pattern    (pattern),
        .repeat_cnt (repeat_cnt),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push(input logic [3:0] o, input logic fixed, input logic s,
                                 input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] c);
        exp_t e;
        e.o       = o;
        e.fixed   = fixed;
        e.d_start = s;
        e.d_pat   = p;
        e.d_cnt   = c;
        exp_q.push_back(e);
    endfunction

    // Expected stream for one transfer: cnt frames of FW bits with GAP idles
    // between them, then one DONE cycle. chain requests a new start in DONE.
    function automatic void add_transfer(input logic [PAT_W-1:0] pat, input int cnt,
                                         input logic chain, input logic [PAT_W-1:0] npat,
                                         input logic [CNT_W-1:0] ncnt);
        for (int f = 0; f < cnt; f++) begin
            for (int b = 0; b < FW; b++) begin
                logic bv;
                bv = (b < PAT_W) ? pat[PAT_W-1-b] : ^pat;
                push({bv, 3'b110}, 1'b0, 1'b0, '0, '0);
            end
            if (f < cnt - 1)
                for (int g = 0; g < GAP; g++) push(4'b0010, 1'b0, 1'b0, '0, '0);
        end
        push(4'b0001, 1'b1, chain, npat, ncnt);
    endfunction

    function automatic void add_idle(input int n);
        for (int i = 0; i < n; i++) push(4'b0000, 1'b1, 1'b0, '0, '0);
    endfunction

    // Drive inputs for the next edge: exact values, or noise that must be ignored.
    task automatic drive_next(input exp_t e);
        if (e.fixed) begin
            start      = e.d_start;
            pattern    = e.d_pat;
            repeat_cnt = e.d_cnt;
        end else begin
            pattern    = PAT_W'($urandom);
            repeat_cnt = CNT_W'($urandom);
            start      = e.o[1] ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        exp_t e;
        int idx;
        cur_test   = "reset";
        reset      = 1'b1;
        start      = 1'b1;
        pattern    = 4'b1011;
        repeat_cnt = 4'd1;
        #1 reset = 1'b0;
        #2;
        obs = {dout, dout_valid, busy, done};
        total_cnt++;
        if (obs !== 4'b0000) $display("FAIL reset_t3 got %b expected 0000", obs);
        else pass_cnt++;
        @(posedge clk);
        #1;
        obs = {dout, dout_valid, busy, done};
        total_cnt++;
        if (obs !== 4'b0000) $display("FAIL reset_after_edge got %b expected 0000", obs);
        else pass_cnt++;
        #6;
        obs = {dout, dout_valid, busy, done};
        total_cnt++;
        if (obs !== 4'b0000) $display("FAIL reset_t12 got %b expected 0000", obs);
        else pass_cnt++;
        #1;
        reset = 1'b1;
        start = 1'b0;
        add_idle(3);
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            obs = {dout, dout_valid, busy, done};
            total_cnt++;
            if (obs !== e.o) $display("FAIL %s cyc=%0d got %b expected %b", cur_test, idx, obs, e.o);
            else pass_cnt++;
            drive_next(e);
            idx++;
        end
        $display("test %s: done, %0d/%0d so far", cur_test, pass_cnt, total_cnt);
    endtask

    // Single transfer with fixed request values and noisy inputs while busy.
    task automatic test_transfer(input string name, input logic [PAT_W-1:0] pat, input int cnt);
        logic [3:0] obs;
        exp_t e;
        int idx;
        cur_test   = name;
        start      = 1'b1;
        pattern    = pat;
        repeat_cnt = CNT_W'(cnt);
        add_transfer(pat, cnt, 1'b0, '0, '0);
        add_idle(2);
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            obs = {dout, dout_valid, busy, done};
            total_cnt++;
            if (obs !== e.o) $display("FAIL %s cyc=%0d got %b expected %b", cur_test, idx, obs, e.o);
            else pass_cnt++;
            drive_next(e);
            idx++;
        end
        $display("test %s: pat=%b cnt=%0d, %0d/%0d so far", name, pat, cnt, pass_cnt, total_cnt);
    endtask

    // start held high through DONE: transfers chain with no idle cycle between.
    task automatic test_back_to_back();
        logic [3:0] obs;
        exp_t e;
        int idx;
        cur_test   = "back_to_back";
        start      = 1'b1;
        pattern    = 4'b0110;
        repeat_cnt = 4'd1;
        add_transfer(4'b0110, 1, 1'b1, 4'b0110, 4'd1);
        add_transfer(4'b0110, 1, 1'b1, 4'b0110, 4'd1);
        add_transfer(4'b0110, 1, 1'b0, '0, '0);
        add_idle(2);
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            obs = {dout, dout_valid, busy, done};
            total_cnt++;
            if (obs !== e.o) $display("FAIL %s cyc=%0d got %b expected %b", cur_test, idx, obs, e.o);
            else pass_cnt++;
            drive_next(e);
            idx++;
        end
        $display("test %s: %0d/%0d so far", cur_test, pass_cnt, total_cnt);
    endtask

    // Reset asserted while the 3rd bit of frame 1 of 3 is on the line.
    task automatic test_reset_mid();
        logic [3:0] obs;
        exp_t e;
        int idx;
        cur_test   = "reset_mid";
        start      = 1'b1;
        pattern    = 4'b1101;
        repeat_cnt = 4'd3;
        add_transfer(4'b1101, 3, 1'b0, '0, '0);
        for (idx = 0; idx < 3; idx++) begin
            e = exp_q.pop_front();
            @(negedge clk);
            obs = {dout, dout_valid, busy, done};
            total_cnt++;
            if (obs !== e.o) $display("FAIL %s cyc=%0d got %b expected %b", cur_test, idx, obs, e.o);
            else pass_cnt++;
            drive_next(e);
        end
        exp_q.delete();
        #2 reset = 1'b0;
        #1;
        obs = {dout, dout_valid, busy, done};
        total_cnt++;
        if (obs !== 4'b0000) $display("FAIL reset_mid_async got %b expected 0000", obs);
        else pass_cnt++;
        @(negedge clk);
        obs = {dout, dout_valid, busy, done};
        total_cnt++;
        if (obs !== 4'b0000) $display("FAIL reset_mid_held got %b expected 0000", obs);
        else pass_cnt++;
        reset = 1'b1;
        start = 1'b0;
        add_idle(4);
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            obs = {dout, dout_valid, busy, done};
            total_cnt++;
            if (obs !== e.o) $display("FAIL %s post cyc=%0d got %b expected %b", cur_test, idx, obs, e.o);
            else pass_cnt++;
            drive_next(e);
            idx++;
        end
        $display("test %s: %0d/%0d so far", cur_test, pass_cnt, total_cnt);
    endtask

    // Random patterns and counts, randomly chained through DONE.
    task automatic test_random(input int n);
        logic [3:0]       obs;
        exp_t             e;
        int               idx;
        logic [PAT_W-1:0] pat, npat;
        logic [CNT_W-1:0] cnt, ncnt;
        logic             chain;
        cur_test   = "random";
        npat       = PAT_W'($urandom);
        ncnt       = CNT_W'($urandom_range(0, 4));
        start      = 1'b1;
        pattern    = npat;
        repeat_cnt = ncnt;
        idx        = 0;
        for (int it = 0; it < n; it++) begin
            pat   = npat;
            cnt   = ncnt;
            npat  = PAT_W'($urandom);
            ncnt  = CNT_W'($urandom_range(0, 4));
            chain = (it < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            add_transfer(pat, int'(cnt), chain, npat, ncnt);
            if (!chain) add_idle(1);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                @(negedge clk);
                obs = {dout, dout_valid, busy, done};
                total_cnt++;
                if (obs !== e.o)
                    $display("FAIL %s txn=%0d pat=%b cnt=%0d cyc=%0d got %b expected %b",
                             cur_test, it, pat, cnt, idx, obs, e.o);
                else pass_cnt++;
                drive_next(e);
                idx++;
            end
            if (!chain && it < n - 1) begin
                start      = 1'b1;
                pattern    = npat;
                repeat_cnt = ncnt;
            end
        end
        $display("test %s: %0d transfers, %0d/%0d so far", cur_test, n, pass_cnt, total_cnt);
    endtask

    initial begin
        start      = 1'b0;
        pattern    = '0;
        repeat_cnt = '0;
        reset      = 1'b1;
        test_reset();
        test_transfer("single_1011", 4'b1011, 1);
        test_transfer("gap_1111x2", 4'b1111, 2);
        test_transfer("zero_count", 4'b1010, 0);
        test_back_to_back();
        test_reset_mid();
        test_transfer("max_count", PAT_W'($urandom), (1 << CNT_W) - 1);
        test_random(25);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
